// File: rtl/qupls_cache_refill_ctrl_if.sv
// Refill controller bus: miss request, memory line fetch and cache array write controls.
// The slave modport is the controller's view; the master modport is the surrounding cache's view.
interface qupls_cache_refill_ctrl_if #(
    parameter int LINES  = 256,
    parameter int WAYS   = 4,
    parameter int AWID   = 32,
    parameter int TAGBIT = 14,
    parameter int BEATS  = 4
);
    localparam int NW = $clog2(LINES);
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic                   req;
    logic [AWID-1:0]        req_adr;
    logic                   hit;
    logic                   req_ack;
    logic                   busy;
    logic [WAYS-1:0]        valid_ways;
    logic                   mem_req;
    logic [AWID-1:0]        mem_adr;
    logic                   mem_ack;
    logic                   mem_rdy;
    logic                   mem_err;
    logic                   wr_en;
    logic [WW-1:0]          wr_way;
    logic [NW-1:0]          wr_ndx;
    logic [BW-1:0]          wr_beat;
    logic                   clr_valid;
    logic                   wr_tag_en;
    logic [AWID-TAGBIT-1:0] tag;
    logic                   set_valid;
    logic                   done;
    logic                   err;

    modport master (
        output req, req_adr, hit, valid_ways, mem_ack, mem_rdy, mem_err,
        input  req_ack, busy, mem_req, mem_adr, wr_en, wr_way, wr_ndx, wr_beat,
               clr_valid, wr_tag_en, tag, set_valid, done, err
    );

    modport slave (
        input  req, req_adr, hit, valid_ways, mem_ack, mem_rdy, mem_err,
        output req_ack, busy, mem_req, mem_adr, wr_en, wr_way, wr_ndx, wr_beat,
               clr_valid, wr_tag_en, tag, set_valid, done, err
    );
endinterface

// File: rtl/qupls_cache_refill_ctrl.sv
// Single-line cache refill sequencer: victim selection, memory fetch in BEATS beats,
// tag/valid commit, with memory error and timeout abort paths.
module qupls_cache_refill_ctrl #(
    parameter int LINES   = 256,
    parameter int WAYS    = 4,
    parameter int AWID    = 32,
    parameter int TAGBIT  = 14,
    parameter int BEATS   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    qupls_cache_refill_ctrl_if.slave bus
);
    localparam int NW = $clog2(LINES);
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LO = TAGBIT - NW;

    localparam logic [AWID-1:0] LINE_MASK = ~((AWID'(1) << LO) - AWID'(1));
    localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [BW-1:0]   BEAT_LAST = BW'(BEATS - 1);
    localparam logic [WW-1:0]   WAY_LAST  = WW'(WAYS - 1);

    typedef enum logic [2:0] {IDLE, VICTIM, REQ, FILL, COMMIT, ERR} state_t;

    state_t          state;
    logic [AWID-1:0] adr_q;
    logic [WW-1:0]   way_q;
    logic [WW-1:0]   rr;
    logic            full_q;
    logic [BW-1:0]   beat;
    logic [TW-1:0]   tmo;
    logic            busy_q;
    logic            mem_req_q;
    logic            clr_valid_q;
    logic            commit_q;
    logic            done_q;
    logic            err_q;

    logic [WW-1:0]   victim;
    logic            set_full;
    logic            waiting;
    logic            progress;
    logic            abort;

    // Lowest free way wins; a full set falls back to the round-robin pointer.
    always_comb begin
        victim   = rr;
        set_full = 1'b1;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!bus.valid_ways[WW'(i)]) begin
                victim   = WW'(i);
                set_full = 1'b0;
            end
        end
    end

    always_comb begin
        waiting  = (state == REQ) || (state == FILL);
        progress = ((state == REQ) && bus.mem_ack) || ((state == FILL) && bus.mem_rdy);
        abort    = waiting && (bus.mem_err || (!progress && (tmo == TMO_LAST)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            adr_q       <= '0;
            way_q       <= '0;
            rr          <= '0;
            full_q      <= 1'b0;
            beat        <= '0;
            tmo         <= '0;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            clr_valid_q <= 1'b0;
            commit_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            clr_valid_q <= 1'b0;
            commit_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            if (abort) begin
                // Memory error beats a simultaneous ack/beat; the line is left invalid.
                state     <= ERR;
                mem_req_q <= 1'b0;
                err_q     <= 1'b1;
                done_q    <= 1'b1;
                tmo       <= '0;
                beat      <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.req) begin
                            if (bus.hit) begin
                                done_q <= 1'b1;
                            end else begin
                                adr_q       <= bus.req_adr;
                                state       <= VICTIM;
                                busy_q      <= 1'b1;
                                clr_valid_q <= 1'b1;
                            end
                        end
                    end
                    VICTIM: begin
                        way_q     <= victim;
                        full_q    <= set_full;
                        state     <= REQ;
                        mem_req_q <= 1'b1;
                        tmo       <= '0;
                    end
                    REQ: begin
                        if (bus.mem_ack) begin
                            state     <= FILL;
                            mem_req_q <= 1'b0;
                            beat      <= '0;
                            tmo       <= '0;
                        end else begin
                            tmo <= tmo + 1'b1;
                        end
                    end
                    FILL: begin
                        if (bus.mem_rdy) begin
                            tmo <= '0;
                            if (beat == BEAT_LAST) begin
                                state    <= COMMIT;
                                commit_q <= 1'b1;
                                done_q   <= 1'b1;
                                beat     <= '0;
                            end else begin
                                beat <= beat + 1'b1;
                            end
                        end else begin
                            tmo <= tmo + 1'b1;
                        end
                    end
                    COMMIT: begin
                        if (full_q)
                            rr <= (rr == WAY_LAST) ? '0 : rr + 1'b1;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                    ERR: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state     <= IDLE;
                        busy_q    <= 1'b0;
                        mem_req_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // The victim is only known while VICTIM sees the set's valid bits, so clr_valid uses it directly.
    assign bus.wr_way    = (state == VICTIM) ? victim : way_q;
    assign bus.req_ack   = bus.req && (state == IDLE);
    assign bus.wr_en     = (state == FILL) && bus.mem_rdy && !bus.mem_err;
    assign bus.busy      = busy_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_adr   = adr_q & LINE_MASK;
    assign bus.wr_ndx    = adr_q[TAGBIT-1 -: NW];
    assign bus.tag       = adr_q[AWID-1:TAGBIT];
    assign bus.wr_beat   = beat;
    assign bus.clr_valid = clr_valid_q;
    assign bus.wr_tag_en = commit_q;
    assign bus.set_valid = commit_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_qupls_cache_refill_ctrl.sv
// Bench for qupls_cache_refill_ctrl: table of refill transactions, a memory responder,
// and a negedge monitor that checks each completion against a queue of expected results.
module tb_qupls_cache_refill_ctrl;
    localparam int LINES = 256, WAYS = 4, AWID = 32, TAGBIT = 14, BEATS = 4, TIMEOUT = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    qupls_cache_refill_ctrl_if #(.LINES(LINES), .WAYS(WAYS), .AWID(AWID),
                                 .TAGBIT(TAGBIT), .BEATS(BEATS)) bus ();

    qupls_cache_refill_ctrl #(.LINES(LINES), .WAYS(WAYS), .AWID(AWID), .TAGBIT(TAGBIT),
                              .BEATS(BEATS), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // errb: -1 clean refill, -2 memory never delivers a beat, >=0 mem_err on that beat.
    typedef struct {
        logic [31:0] adr;
        bit          hit;
        logic [3:0]  vw;
        int          errb;
        logic [1:0]  way;
        int          hold;
    } vec_t;

    typedef struct {
        bit          hit;
        bit          err;
        logic [1:0]  way;
        logic [7:0]  ndx;
        logic [17:0] tag;
        logic [31:0] madr;
        int          nb;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event seen, expected none", name);
    endtask

    function automatic exp_t model(input vec_t v);
        exp_t e;
        e.hit  = v.hit;
        e.err  = (v.errb != -1);
        e.way  = v.way;
        e.ndx  = v.adr[13:6];
        e.tag  = v.adr[31:14];
        e.madr = {v.adr[31:6], 6'b0};
        if (v.hit) begin
            e.nb = 0;  e.lat = 1;
        end else if (v.errb == -1) begin
            e.nb = BEATS;  e.lat = 3 + BEATS;
        end else if (v.errb == -2) begin
            e.nb = 0;  e.lat = 3 + TIMEOUT;
        end else begin
            e.nb = v.errb;  e.lat = 4 + v.errb;
        end
        return e;
    endfunction

    task automatic check_all_zero(input string p);
        check({p, "_busy"},      bus.busy, 0);
        check({p, "_req_ack"},   bus.req_ack, 0);
        check({p, "_mem_req"},   bus.mem_req, 0);
        check({p, "_mem_adr"},   bus.mem_adr, 0);
        check({p, "_wr_en"},     bus.wr_en, 0);
        check({p, "_wr_way"},    bus.wr_way, 0);
        check({p, "_wr_ndx"},    bus.wr_ndx, 0);
        check({p, "_wr_beat"},   bus.wr_beat, 0);
        check({p, "_clr_valid"}, bus.clr_valid, 0);
        check({p, "_wr_tag_en"}, bus.wr_tag_en, 0);
        check({p, "_tag"},       bus.tag, 0);
        check({p, "_set_valid"}, bus.set_valid, 0);
        check({p, "_done"},      bus.done, 0);
        check({p, "_err"},       bus.err, 0);
    endtask

    // Monitor: latency from req_ack, victim on clr_valid, beats, and completion vs scoreboard.
    int   t0 = 0;
    int   nb = 0;
    bit   mr_seen = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.req_ack) begin
                t0 = cyc;  nb = 0;  mr_seen = 1'b0;
            end
            if (bus.clr_valid) begin
                check("clr_lat", cyc - t0, 1);
                if (sb.size() > 0) check("victim_way", bus.wr_way, sb[0].way);
                else fail("clr_valid_unexpected");
            end
            if (bus.mem_req && !mr_seen) begin
                mr_seen = 1'b1;
                if (sb.size() == 0 || sb[0].hit) fail("mem_req_unexpected");
                else begin
                    check("mreq_lat", cyc - t0, 2);
                    check("mem_adr", bus.mem_adr, sb[0].madr);
                end
            end
            if (bus.wr_en) begin
                check("wr_beat", bus.wr_beat, nb);
                check("beat_lat", cyc - t0, 3 + nb);
                nb++;
            end
            if (bus.done) begin
                if (sb.size() == 0) fail("done_unexpected");
                else begin
                    mon_e = sb.pop_front();
                    check("done_lat", cyc - t0, mon_e.lat);
                    check("err", bus.err, mon_e.err);
                    check("set_valid", bus.set_valid, !mon_e.err && !mon_e.hit);
                    check("wr_tag_en", bus.wr_tag_en, !mon_e.err && !mon_e.hit);
                    check("beat_count", nb, mon_e.nb);
                    if (mon_e.hit) check("hit_busy", bus.busy, 0);
                    else begin
                        check("done_way", bus.wr_way, mon_e.way);
                        check("done_ndx", bus.wr_ndx, mon_e.ndx);
                        check("done_tag", bus.tag, mon_e.tag);
                    end
                end
            end
            if ((bus.set_valid || bus.wr_tag_en || bus.err) && !bus.done) fail("commit_without_done");
        end
    end

    // Drives one request and plays a zero-wait memory that acks at once and streams beats.
    task automatic do_txn(input vec_t v);
        int beats = 0;
        bit filling = 1'b0;
        bit fin = 1'b0;
        @(posedge clk); #1;
        bus.req = 1'b1;  bus.req_adr = v.adr;  bus.hit = v.hit;  bus.valid_ways = v.vw;
        sb.push_back(model(v));
        @(negedge clk);
        check("ack", bus.req_ack, 1);
        check("ack_busy", bus.busy, 0);
        for (int c = 0; c < 400 && !fin; c++) begin
            @(posedge clk); #1;
            bus.req = (c < v.hold);
            if (bus.req) begin
                bus.req_adr = ~v.adr;  bus.hit = 1'b0;
            end
            bus.mem_ack = 1'b0;  bus.mem_rdy = 1'b0;  bus.mem_err = 1'b0;
            if (!bus.busy) fin = 1'b1;
            else if (bus.mem_req) begin
                bus.mem_ack = 1'b1;  filling = 1'b1;
            end else if (filling && v.errb != -2 && beats < BEATS) begin
                bus.mem_rdy = 1'b1;
                if (beats == v.errb) begin
                    bus.mem_err = 1'b1;  filling = 1'b0;
                end
                beats++;
            end
            if (bus.req) begin
                @(negedge clk);
                check("busy_noack", bus.req_ack, 0);
            end
        end
        if (!fin) fail("txn_hang");
        bus.req = 1'b0;  bus.hit = 1'b0;
        bus.mem_ack = 1'b0;  bus.mem_rdy = 1'b0;  bus.mem_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vr;
        tbl[0]  = '{32'h0001_2340, 1'b0, 4'b0000, -1, 2'd0, 0};
        tbl[1]  = '{32'h0000_4A80, 1'b0, 4'b1011, -1, 2'd2, 0};
        tbl[2]  = '{32'h1234_5678, 1'b0, 4'b1111, -1, 2'd0, 0};
        tbl[3]  = '{32'h0ABC_DE00, 1'b0, 4'b1111, -1, 2'd1, 3};
        tbl[4]  = '{32'h7FFF_FFC0, 1'b0, 4'b1111, -1, 2'd2, 0};
        tbl[5]  = '{32'h8000_0040, 1'b0, 4'b1111, -1, 2'd3, 0};
        tbl[6]  = '{32'hDEAD_BEEF, 1'b0, 4'b1111, -1, 2'd0, 0};
        tbl[7]  = '{32'hCAFE_0000, 1'b1, 4'b0000, -1, 2'd0, 0};
        tbl[8]  = '{32'h0000_0FC0, 1'b0, 4'b1111,  2, 2'd1, 0};
        tbl[9]  = '{32'h3333_3300, 1'b0, 4'b1111, -1, 2'd1, 0};
        tbl[10] = '{32'h0000_1000, 1'b0, 4'b1110, -1, 2'd0, 0};
        tbl[11] = '{32'h4444_4440, 1'b0, 4'b0100, -2, 2'd0, 0};

        bus.req = 1'b0;  bus.req_adr = '0;  bus.hit = 1'b0;  bus.valid_ways = '0;
        bus.mem_ack = 1'b0;  bus.mem_rdy = 1'b0;  bus.mem_err = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) do_txn(tbl[i]);

        // Reset in the middle of a full-set refill; round-robin pointer is at 2 here.
        vr = '{32'h0055_5500, 1'b0, 4'b1111, -1, 2'd2, 0};
        @(posedge clk); #1;
        bus.req = 1'b1;  bus.req_adr = vr.adr;  bus.hit = 1'b0;  bus.valid_ways = vr.vw;
        sb.push_back(model(vr));
        @(posedge clk); #1;  bus.req = 1'b0;
        @(posedge clk); #1;  bus.mem_ack = 1'b1;
        @(posedge clk); #1;  bus.mem_ack = 1'b0;  bus.mem_rdy = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_busy", bus.busy, 1);
        check("pre_rst_wr_en", bus.wr_en, 1);
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        bus.mem_rdy = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;

        // First refill after reset: full set must pick way 0 again.
        vr = '{32'h0066_6600, 1'b0, 4'b1111, -1, 2'd0, 0};
        do_txn(vr);
        vr = '{32'h0077_7700, 1'b0, 4'b1111, -1, 2'd1, 0};
        do_txn(vr);

        repeat (3) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
